// File: rtl/gshare_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gshare_pkg : shared constants and helpers for the gshare predictor          |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
package gshare_pkg;

    localparam int C_INIT_CTR_DEFAULT = 1;

    // XOR-fold pc[31:2] into idx_bits-wide chunks; the top chunk is zero-extended.
    function automatic logic [31:0] fold_pc(input logic [31:0] pc, input int idx_bits);
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] acc;
        word = {2'b00, pc[31:2]};
        mask = (32'd1 << idx_bits) - 32'd1;
        acc  = '0;
        for (int i = 0; i < 30; i++) begin
            if ((i % idx_bits) == 0) begin
                acc = acc ^ ((word >> i) & mask);
            end
        end
        return acc;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] ctr, input int bits);
        logic [31:0] max;
        max = (32'd1 << bits) - 32'd1;
        return (ctr >= max) ? max : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gshare_pht : flop-based counter table with valid vector, 1R/1W              |
// | Revision   : 1.0                                                            |
// +-----------------------------------------------------------------------------+
module gshare_pht
    import gshare_pkg::*;
#(
    parameter int ENTRIES  = 256,
    parameter int IDX_BITS = $clog2(ENTRIES),
    parameter int CTR_BITS = 2,
    parameter int INIT_CTR = C_INIT_CTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_index_i,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_index_i,
    input  logic [CTR_BITS-1:0] wr_ctr_i
);

    logic [CTR_BITS-1:0] pht_q [ENTRIES];
    logic [ENTRIES-1:0]  valid_q;

    // Counter storage is deliberately left unreset; the valid vector masks it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            pht_q[wr_index_i] <= wr_ctr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    assign rd_ctr_o = valid_q[rd_index_i] ? pht_q[rd_index_i] : CTR_BITS'(INIT_CTR);

endmodule
`default_nettype wire

// File: rtl/gshare_spec_predictor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | gshare_spec_predictor : gshare predictor with speculative, checkpointed GHR |
// | Revision              : 1.0                                                 |
// +-----------------------------------------------------------------------------+
module gshare_spec_predictor
    import gshare_pkg::*;
#(
    parameter int GHR_BITS    = 8,
    parameter int PHT_ENTRIES = 256,
    parameter int CTR_BITS    = 2,
    parameter int INIT_CTR    = C_INIT_CTR_DEFAULT,
    parameter int IDX_BITS    = $clog2(PHT_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    output logic                resp_valid_o,
    output logic                resp_taken_o,
    output logic [CTR_BITS-1:0] resp_ctr_o,
    output logic [IDX_BITS-1:0] resp_index_o,
    output logic [GHR_BITS-1:0] resp_ghr_o,
    input  logic                upd_valid_i,
    input  logic [IDX_BITS-1:0] upd_index_i,
    input  logic [CTR_BITS-1:0] upd_ctr_i,
    input  logic [GHR_BITS-1:0] upd_ghr_i,
    input  logic                upd_taken_i,
    input  logic                upd_mispredict_i
);

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                s1_valid_q;
    logic [IDX_BITS-1:0] s1_index_q;
    logic [GHR_BITS-1:0] s1_ghr_q;

    logic                w_mispredict;
    logic                w_resp_valid;
    logic [CTR_BITS-1:0] w_rd_ctr;
    logic [GHR_BITS-1:0] w_ghr_eff;
    logic [IDX_BITS-1:0] w_hist;
    logic [IDX_BITS-1:0] w_fold;
    logic [IDX_BITS-1:0] w_pred_index;
    logic [CTR_BITS-1:0] w_wr_ctr;

    assign w_mispredict = upd_valid_i & upd_mispredict_i;
    // A recovering mispredict kills the response emerging in the same cycle.
    assign w_resp_valid = s1_valid_q & ~w_mispredict;

    gshare_pht #(
        .ENTRIES  (PHT_ENTRIES),
        .IDX_BITS (IDX_BITS),
        .CTR_BITS (CTR_BITS),
        .INIT_CTR (INIT_CTR)
    ) u_pht (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (s1_index_q),
        .rd_ctr_o   (w_rd_ctr),
        .wr_en_i    (upd_valid_i),
        .wr_index_i (upd_index_i),
        .wr_ctr_i   (w_wr_ctr)
    );

    assign resp_valid_o = w_resp_valid;
    assign resp_ctr_o   = w_resp_valid ? w_rd_ctr   : '0;
    assign resp_index_o = w_resp_valid ? s1_index_q : '0;
    assign resp_ghr_o   = w_resp_valid ? s1_ghr_q   : '0;
    assign resp_taken_o = resp_ctr_o[CTR_BITS-1];

    assign w_ghr_eff = w_resp_valid ? {ghr_q[GHR_BITS-2:0], resp_taken_o} : ghr_q;

    generate
        if (GHR_BITS >= IDX_BITS) begin : g_hist_trunc
            assign w_hist = w_ghr_eff[IDX_BITS-1:0];
        end else begin : g_hist_zext
            assign w_hist = {{(IDX_BITS-GHR_BITS){1'b0}}, w_ghr_eff};
        end
    endgenerate

    assign w_fold       = IDX_BITS'(fold_pc(pred_pc_i, IDX_BITS));
    assign w_pred_index = w_fold ^ w_hist;

    assign w_wr_ctr = upd_taken_i ? CTR_BITS'(sat_inc(32'(upd_ctr_i), CTR_BITS))
                                  : CTR_BITS'(sat_dec(32'(upd_ctr_i)));

    always_comb begin
        ghr_d = ghr_q;
        if (w_mispredict) begin
            ghr_d = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i};
        end else if (w_resp_valid) begin
            ghr_d = w_ghr_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_ghr_q   <= '0;
        end else begin
            ghr_q      <= ghr_d;
            s1_valid_q <= pred_valid_i & ~w_mispredict;
            if (pred_valid_i) begin
                s1_index_q <= w_pred_index;
                s1_ghr_q   <= w_ghr_eff;
            end
        end
    end

endmodule
`default_nettype wire
